// File: rtl/nibble_rx_if.sv
// nibble_rx_if: serial line in, parallel load-register bus and status flags out.
interface nibble_rx_if #(parameter int DATA_W = 4);
   logic              rxd;
   logic [DATA_W-1:0] da;
   logic              load;
   logic              perr;
   logic              ferr;
   logic              busy;
   modport master (input rxd, output da, load, perr, ferr, busy);
   modport slave  (output rxd, input da, load, perr, ferr, busy);
endinterface

// File: rtl/nibble_rx.sv
// nibble_rx: receives start/data/parity/stop framed nibbles on rxd and
// pulses load with the word on da; bad frames are dropped and flagged.
module nibble_rx #(
   parameter int BIT_TICKS = 8,
   parameter int DATA_W    = 4,
   parameter int PARITY_EN = 1
) (
   input  logic         clk,
   input  logic         clr_n,
   nibble_rx_if.master  bus
);
   localparam int TW = $clog2(BIT_TICKS);
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [TW-1:0] T_END = TW'(BIT_TICKS - 1);
   localparam logic [TW-1:0] T_MID = TW'(BIT_TICKS / 2 - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
   state_t            state_q, state_d;
   logic              s1_q, rs_q;
   logic [TW-1:0]     tick_q, tick_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d, da_q, da_d;
   logic              err_q, err_d, load_q, load_d, perr_q, perr_d, ferr_q, ferr_d;
   logic              ttop;
   assign ttop = tick_q == T_END;
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      err_d   = err_q;
      da_d    = da_q;
      load_d  = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            err_d   = 1'b0;
            state_d = rs_q ? IDLE : START;
         end
         START: if (tick_q == T_MID) begin
            state_d = rs_q ? IDLE : DATA;
            bit_d   = '0;
         end
         DATA: if (ttop) begin
            shift_d[bit_q] = rs_q;
            bit_d          = bit_q + 1'b1;
            if (bit_q == BW'(DATA_W - 1)) state_d = (PARITY_EN != 0) ? PARITY : STOP;
         end
         PARITY: if (ttop) begin
            err_d   = ^shift_q ^ rs_q;
            state_d = STOP;
         end
         STOP: if (ttop) begin
            // a low stop bit wins over a parity error
            ferr_d  = !rs_q;
            perr_d  = rs_q && err_q;
            load_d  = rs_q && !err_q;
            da_d    = (rs_q && !err_q) ? shift_q : da_q;
            state_d = rs_q ? IDLE : BREAK;
         end
         BREAK: state_d = rs_q ? IDLE : BREAK;
         default: state_d = IDLE;
      endcase
      tick_d = (state_d != state_q || ttop) ? '0 : tick_q + 1'b1;
   end
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= IDLE;
         s1_q    <= 1'b1;
         rs_q    <= 1'b1;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         da_q    <= '0;
         err_q   <= 1'b0;
         load_q  <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s1_q    <= bus.rxd;
         rs_q    <= s1_q;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         da_q    <= da_d;
         err_q   <= err_d;
         load_q  <= load_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end
   assign bus.da   = da_q;
   assign bus.load = load_q;
   assign bus.perr = perr_q;
   assign bus.ferr = ferr_q;
   assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_nibble_rx.sv
// tb_nibble_rx: directed and random frames against a frame-level scoreboard.
module tb_nibble_rx;
   localparam int BT  = 8;
   localparam int DW  = 4;
   localparam int PE  = 1;
   localparam int LAT = 2 + BT / 2 + (DW + PE + 1) * BT + 1;
   typedef struct {int kind; int data; int cyc;} exp_t;
   logic clk = 1'b0;
   logic clr_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   da_ref = 0;
   exp_t q[$];
   nibble_rx_if #(.DATA_W(DW)) bus ();
   nibble_rx #(.BIT_TICKS(BT), .DATA_W(DW), .PARITY_EN(PE)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, req);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send_bit(input logic b);
      bus.rxd = b;
      tick(BT);
   endtask
   // kind 0 = good frame, 1 = parity error, 2 = framing error
   task automatic send_frame(input logic [DW-1:0] d, input bit pbad, input bit stop);
      exp_t e;
      e.cyc  = cyc + LAT;
      e.kind = !stop ? 2 : pbad ? 1 : 0;
      if (e.kind == 0) da_ref = int'(d);
      e.data = da_ref;
      q.push_back(e);
      send_bit(1'b0);
      for (int i = 0; i < DW; i++) send_bit(d[i]);
      if (PE != 0) send_bit((^d) ^ pbad);
      send_bit(stop);
   endtask
   always @(negedge clk) begin
      if (clr_n && (bus.load || bus.perr || bus.ferr)) begin
         chk("flags_exclusive", int'($onehot0({bus.load, bus.perr, bus.ferr})), 1);
         if (q.size() == 0) chk("unexpected_event", 1, 0);
         else begin
            exp_t e;
            int d;
            e = q.pop_front();
            chk("event_kind", bus.load ? 0 : bus.perr ? 1 : 2, e.kind);
            chk("event_da", int'(bus.da), e.data);
            d = cyc - e.cyc;
            chk("event_latency", int'(d >= -1 && d <= 1), 1);
            if (bus.load) chk("busy_low_on_load", int'(bus.busy), 0);
         end
      end
   end
   initial begin
      bit seen;
      bus.rxd = 1'b1;
      tick(3);
      chk("rst_da", int'(bus.da), 0);
      chk("rst_load", int'(bus.load), 0);
      chk("rst_perr", int'(bus.perr), 0);
      chk("rst_ferr", int'(bus.ferr), 0);
      chk("rst_busy", int'(bus.busy), 0);
      clr_n = 1'b1;
      tick(2 * BT);
      send_frame(4'hB, 1'b0, 1'b1);
      tick(2);
      chk("busy_after_frame", int'(bus.busy), 0);
      tick(BT);
      send_frame(4'hB, 1'b1, 1'b1);
      tick(BT);
      send_frame(4'h5, 1'b0, 1'b0);
      tick(40);
      bus.rxd = 1'b1;
      tick(2 * BT);
      send_frame(4'h6, 1'b0, 1'b1);
      tick(BT);
      bus.rxd = 1'b0;
      tick(2);
      bus.rxd = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         tick(1);
         seen |= bus.busy;
      end
      chk("glitch_busy_seen", int'(seen), 1);
      chk("glitch_back_idle", int'(bus.busy), 0);
      chk("glitch_da_kept", int'(bus.da), da_ref);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      bus.rxd = 1'b0;
      tick(3);
      clr_n = 1'b0;
      #1;
      da_ref = 0;
      chk("midrst_da", int'(bus.da), 0);
      chk("midrst_load", int'(bus.load), 0);
      chk("midrst_perr", int'(bus.perr), 0);
      chk("midrst_ferr", int'(bus.ferr), 0);
      chk("midrst_busy", int'(bus.busy), 0);
      tick(3);
      bus.rxd = 1'b1;
      clr_n = 1'b1;
      tick(2 * BT);
      send_frame(4'h9, 1'b0, 1'b1);
      tick(BT);
      send_frame(4'h3, 1'b0, 1'b1);
      send_frame(4'hC, 1'b0, 1'b1);
      tick(BT);
      for (int i = 0; i < 40; i++) begin
         logic [DW-1:0] d;
         bit pbad, stop;
         d    = DW'($urandom_range(0, 15));
         pbad = $urandom_range(0, 4) == 0;
         stop = $urandom_range(0, 5) != 0;
         send_frame(d, pbad, stop);
         if (!stop) begin
            tick($urandom_range(0, 20));
            bus.rxd = 1'b1;
            tick(2 * BT);
         end else tick($urandom_range(0, 12));
      end
      for (int i = 0; i < 300 && q.size() > 0; i++) tick(1);
      chk("queue_drained", q.size(), 0);
      chk("final_da", int'(bus.da), da_ref);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
